mux_2_1_rr_arbiter: RTL and testbench

MUX_2_1_RR_ARBITER -- requirements
Module: mux_2_1_rr_arbiter

---
 rtl/mux_2_1_rr_arbiter.sv | 73 +++++++
 tb/tb_mux_2_1_rr_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mux_2_1_rr_arbiter.sv
// Two-channel round-robin arbiter feeding a single registered output stage with
// valid/ready handshaking and a wrapping count of completed output transfers.
module mux_2_1_rr_arbiter #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   Clock_In,
   input  logic                   Reset_N_In,
   input  logic                   Enable_In,
   input  logic [DATA_WIDTH-1:0]  Data_0_In,
   input  logic                   Data_0_Valid_In,
   output logic                   Data_0_Ready_Out,
   input  logic [DATA_WIDTH-1:0]  Data_1_In,
   input  logic                   Data_1_Valid_In,
   output logic                   Data_1_Ready_Out,
   output logic [DATA_WIDTH-1:0]  MUX_Data_Out,
   output logic                   MUX_Select_Out,
   output logic                   MUX_Valid_Out,
   input  logic                   MUX_Ready_In,
   output logic [COUNT_WIDTH-1:0] Transfer_Count_Out
);

   logic [DATA_WIDTH-1:0]  r_data;
   logic                   r_sel;
   logic                   r_valid;
   logic                   r_last_grant;
   logic [COUNT_WIDTH-1:0] r_count;

   logic w_load_en;
   logic w_xfer;
   logic w_grant;
   logic w_grant_idx;

   // Grants are gated by reset so no word is ever accepted while in reset.
   always_comb begin
      w_load_en   = !r_valid || MUX_Ready_In;
      w_xfer      = r_valid && MUX_Ready_In;
      w_grant     = Reset_N_In && Enable_In && w_load_en &&
                    (Data_0_Valid_In || Data_1_Valid_In);
      w_grant_idx = (Data_0_Valid_In && Data_1_Valid_In) ? ~r_last_grant
                                                         : Data_1_Valid_In;
   end

   always_ff @(posedge Clock_In) begin
      if (!Reset_N_In) begin
         r_data       <= '0;
         r_sel        <= 1'b0;
         r_valid      <= 1'b0;
         r_last_grant <= 1'b1;
         r_count      <= '0;
      end else begin
         if (w_grant) begin
            r_data       <= w_grant_idx ? Data_1_In : Data_0_In;
            r_sel        <= w_grant_idx;
            r_valid      <= 1'b1;
            r_last_grant <= w_grant_idx;
         end else if (w_xfer) begin
            r_valid <= 1'b0;
         end
         if (w_xfer) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign Data_0_Ready_Out   = w_grant && !w_grant_idx;
   assign Data_1_Ready_Out   = w_grant &&  w_grant_idx;
   assign MUX_Data_Out       = r_data;
   assign MUX_Select_Out     = r_sel;
   assign MUX_Valid_Out      = r_valid;
   assign Transfer_Count_Out = r_count;

endmodule

// File: tb/tb_mux_2_1_rr_arbiter.sv
// Bench for mux_2_1_rr_arbiter (4-bit counter so wrap is reachable): directed
// cycle table with hand-derived expectations, then a random scoreboard phase.
module tb_mux_2_1_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n, en, v0, v1, rdy;
   logic [7:0] d0, d1;
   logic       r0, r1, sel, val;
   logic [7:0] data;
   logic [3:0] cnt;

   always #5 clk = ~clk;

   mux_2_1_rr_arbiter #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut (
      .Clock_In(clk), .Reset_N_In(rst_n), .Enable_In(en),
      .Data_0_In(d0), .Data_0_Valid_In(v0), .Data_0_Ready_Out(r0),
      .Data_1_In(d1), .Data_1_Valid_In(v1), .Data_1_Ready_Out(r1),
      .MUX_Data_Out(data), .MUX_Select_Out(sel), .MUX_Valid_Out(val),
      .MUX_Ready_In(rdy), .Transfer_Count_Out(cnt)
   );

   typedef struct {
      logic       rst_n, en, v0;
      logic [7:0] d0;
      logic       v1;
      logic [7:0] d1;
      logic       rdy;
      logic       r0, r1;        // expected during the cycle
      logic       val;           // expected after the edge
      logic [7:0] data;
      logic       sel;
      logic [3:0] cnt;
   } vec_t;

   vec_t tbl[$];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic add(input logic rs, e, a0, input logic [7:0] x0, input logic a1,
                      input logic [7:0] x1, input logic rd, er0, er1, ev,
                      input logic [7:0] ed, input logic es, input logic [3:0] ec);
      vec_t v;
      v = '{rs, e, a0, x0, a1, x1, rd, er0, er1, ev, ed, es, ec};
      tbl.push_back(v);
   endtask

   task automatic drive(input logic rs, e, a0, input logic [7:0] x0, input logic a1,
                        input logic [7:0] x1, input logic rd);
      rst_n = rs; en = e; v0 = a0; d0 = x0; v1 = a1; d1 = x1; rdy = rd;
   endtask

   logic [8:0] sb[$];
   logic       m_valid, m_last, m_grant, m_idx;
   logic [3:0] m_cnt;
   logic [8:0] w;

   initial begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

      // rst en v0 d0 v1 d1 rdy | r0 r1 | val data sel cnt
      add(0,1,1,8'hA5,1,8'h3C,1, 0,0, 0,8'h00,0,4'd0);  // reset, readies low
      add(1,1,1,8'hA5,1,8'h3C,1, 1,0, 1,8'hA5,0,4'd0);  // first contention -> ch0
      add(1,1,1,8'hA5,1,8'h3C,1, 0,1, 1,8'h3C,1,4'd1);
      add(1,1,1,8'hA5,1,8'h3C,1, 1,0, 1,8'hA5,0,4'd2);
      add(1,1,1,8'hA5,1,8'h3C,1, 0,1, 1,8'h3C,1,4'd3);
      for (int unsigned i = 0; i < 3; i++)                // only ch1 valid
         add(1,1,0,8'h00,1,8'h77,1, 0,1, 1,8'h77,1,4'(4+i));
      add(1,1,1,8'h11,0,8'h00,1, 1,0, 1,8'h11,0,4'd7);  // load 0x11 (last=0)
      for (int unsigned i = 0; i < 4; i++)                // stall, both valid
         add(1,1,1,8'h22,1,8'h33,0, 0,0, 1,8'h11,0,4'd7);
      add(1,1,1,8'h22,1,8'h33,1, 0,1, 1,8'h33,1,4'd8);  // drain + load ch1
      add(1,0,1,8'h22,1,8'h33,1, 0,0, 0,8'h33,1,4'd9);  // disabled: drain only
      add(1,0,1,8'h22,1,8'h33,1, 0,0, 0,8'h33,1,4'd9);
      add(1,1,1,8'h22,1,8'h33,0, 1,0, 1,8'h22,0,4'd9);  // last grant kept at 1
      add(0,1,1,8'hA5,1,8'h3C,1, 0,0, 0,8'h00,0,4'd0);  // reset discards word
      for (int unsigned k = 0; k <= 16; k++)              // ch0 wins, then wrap
         add(1,1,1,8'hA5,1,8'h3C,1, (k%2==0),(k%2==1), 1,
             (k%2==1) ? 8'h3C : 8'hA5, (k%2==1), 4'(k));
      add(1,1,0,8'h00,0,8'h00,1, 0,0, 0,8'hA5,0,4'd1);  // drain, no grant

      @(posedge clk); #1;
      foreach (tbl[i]) begin
         drive(tbl[i].rst_n, tbl[i].en, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].rdy);
         #3;
         check($sformatf("vec%0d ready0", i), 32'(r0), 32'(tbl[i].r0));
         check($sformatf("vec%0d ready1", i), 32'(r1), 32'(tbl[i].r1));
         @(posedge clk); #1;
         check($sformatf("vec%0d valid", i), 32'(val), 32'(tbl[i].val));
         check($sformatf("vec%0d data", i), 32'(data), 32'(tbl[i].data));
         check($sformatf("vec%0d sel", i), 32'(sel), 32'(tbl[i].sel));
         check($sformatf("vec%0d count", i), 32'(cnt), 32'(tbl[i].cnt));
      end

      // Random phase: model predicts grants, pushes words, pops on transfer.
      drive(1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1);
      @(posedge clk); #1;
      m_valid = 1'b0; m_last = 1'b1; m_cnt = '0;
      for (int unsigned c = 0; c < 300; c++) begin
         drive(1'b1, ($urandom_range(0, 9) < 8), $urandom_range(0, 1), 8'($urandom),
               $urandom_range(0, 1), 8'($urandom), ($urandom_range(0, 9) < 7));
         #3;
         m_grant = en && (!m_valid || rdy) && (v0 || v1);
         if (v0 && v1)  m_idx = !m_last;
         else if (v1)   m_idx = 1'b1;
         else           m_idx = 1'b0;
         check("rnd valid", 32'(val), 32'(m_valid));
         check("rnd ready0", 32'(r0), 32'(m_grant && !m_idx));
         check("rnd ready1", 32'(r1), 32'(m_grant && m_idx));
         if (m_valid && rdy) begin
            if (sb.size() == 0) begin
               check("rnd scoreboard empty", 32'(1), 32'(0));
            end else begin
               w = sb.pop_front();
               check("rnd word", 32'({sel, data}), 32'(w));
            end
            m_cnt++;
            m_valid = 1'b0;
         end
         if (m_grant) begin
            sb.push_back({m_idx, m_idx ? d1 : d0});
            m_valid = 1'b1;
            m_last  = m_idx;
         end
         @(posedge clk); #1;
      end
      check("rnd count", 32'(cnt), 32'(m_cnt));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
